// File: rtl/lfsr_seed_sequencer_if.sv
// ---------------------------------------------------------------------------
// lfsr_seed_sequencer_if
// Frame bundle between the seed sequencer and the downstream LFSR stage.
//   seed_out    : frame seed (RW bits)
//   probability : probability snapshot for the frame (CW bits)
//   count       : wrapping frame counter (CW bits)
//   seed_valid  : bundle is valid
//   seed_ready  : consumer accepts the bundle
// master = sequencer side, slave = consumer side.
// ---------------------------------------------------------------------------
`ifndef RNDSIZE
`define RNDSIZE 16
`endif

interface lfsr_seed_sequencer_if #(
  parameter int RW = `RNDSIZE,
  parameter int CW = 4
);
  logic [RW-1:0] seed_out;
  logic [CW-1:0] probability;
  logic [CW-1:0] count;
  logic          seed_valid;
  logic          seed_ready;

  modport master (
    output seed_out, probability, count, seed_valid,
    input  seed_ready
  );

  modport slave (
    input  seed_out, probability, count, seed_valid,
    output seed_ready
  );
endinterface

// File: rtl/lfsr_seed_sequencer.sv
// ---------------------------------------------------------------------------
// lfsr_seed_sequencer
// Per-frame seed source for the combinational segment-probability LFSR stage.
// On req it advances the `RNDSIZE-bit LFSR by STEPS shifts (one per cycle),
// then presents {seed_out, probability, count} on a valid/ready bundle.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   init_seed   : seed loaded by init_load
//   init_load   : load LFSR, force IDLE (overrides everything else)
//   prob_in     : new probability code, written on prob_we
//   prob_we     : probability register write strobe (any state)
//   req         : start a frame (sampled only in IDLE)
//   busy        : high in STEP or VALID
//   bus         : master side of lfsr_seed_sequencer_if
//
// Configuration macro:
//   LFSR_SEED_LOCKUP_GUARD_EN - when defined, any load or shift that would
//   leave the LFSR all-zero writes 1 instead.
// ---------------------------------------------------------------------------
`ifndef RNDSIZE
`define RNDSIZE 16
`endif

module lfsr_seed_sequencer #(
  parameter int                     STEPS        = 16,
  parameter int                     COUNTERSIZE  = 4,
  parameter logic [COUNTERSIZE-1:0] PROB_DEFAULT = 4'b0011
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`RNDSIZE-1:0]    init_seed,
  input  logic                   init_load,
  input  logic [COUNTERSIZE-1:0] prob_in,
  input  logic                   prob_we,
  input  logic                   req,
  output logic                   busy,
  lfsr_seed_sequencer_if.master  bus
);

  localparam int         RW      = `RNDSIZE;
  localparam logic [7:0] STEPS_L = 8'(STEPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_VALID
  } state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          lfsr_q, lfsr_d;
  logic [7:0]             steps_left_q, steps_left_d;
  logic [RW-1:0]          seed_q, seed_d;
  logic [COUNTERSIZE-1:0] prob_reg_q, prob_reg_d;
  logic [COUNTERSIZE-1:0] prob_out_q, prob_out_d;
  logic [COUNTERSIZE-1:0] count_q, count_d;
  logic [RW-1:0]          lfsr_shifted;

  // Same polynomial as the downstream stage.
  function automatic logic [RW-1:0] lfsr_next(input logic [RW-1:0] s);
    logic fb;
    fb = s[RW-1] ^ s[3] ^ s[2] ^ s[0];
    return {s[RW-2:0], fb};
  endfunction

  // Applied to every value written into the LFSR state.
  function automatic logic [RW-1:0] lockup_fix(input logic [RW-1:0] s);
`ifdef LFSR_SEED_LOCKUP_GUARD_EN
    return (s == '0) ? RW'(1) : s;
`else
    return s;
`endif
  endfunction

  assign lfsr_shifted = lockup_fix(lfsr_next(lfsr_q));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case/if tree leaves it unassigned (no latches).
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    steps_left_d = steps_left_q;
    seed_d       = seed_q;
    prob_out_d   = prob_out_q;
    count_d      = count_q;
    prob_reg_d   = prob_we ? prob_in : prob_reg_q;

    if (init_load) begin
      // Abort: reload and drop back to IDLE; seed_out and count are kept.
      lfsr_d  = lockup_fix(init_seed);
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_d      = S_STEP;
            steps_left_d = STEPS_L;
          end
        end
        S_STEP: begin
          lfsr_d       = lfsr_shifted;
          steps_left_d = steps_left_q - 8'd1;
          if (steps_left_q == 8'd1) begin
            state_d    = S_VALID;
            seed_d     = lfsr_shifted;
            // Snapshot taken here keeps probability stable through VALID
            // even if prob_we fires during backpressure.
            prob_out_d = prob_reg_q;
          end
        end
        S_VALID: begin
          if (bus.seed_ready) begin
            count_d = count_q + COUNTERSIZE'(1);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= RW'(1);
      steps_left_q <= '0;
      seed_q       <= '0;
      prob_reg_q   <= PROB_DEFAULT;
      prob_out_q   <= PROB_DEFAULT;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      steps_left_q <= steps_left_d;
      seed_q       <= seed_d;
      prob_reg_q   <= prob_reg_d;
      prob_out_q   <= prob_out_d;
      count_q      <= count_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign bus.seed_valid  = (state_q == S_VALID);
  assign bus.seed_out    = seed_q;
  assign bus.probability = prob_out_q;
  assign bus.count       = count_q;

endmodule

// File: doc/lfsr_seed_sequencer.md
# lfsr_seed_sequencer

Sequential seed source that sits directly upstream of the combinational segment-probability LFSR stage. Per display frame it advances an RNDSIZE-bit LFSR state by a fixed number of shifts and presents the resulting seed with a valid/ready handshake. It also presents a per-frame probability code and a wrapping frame counter, so the downstream stage receives `seed`, `probability` and `count` as one stable bundle.

## Interface
Parameters:
- STEPS, 16: number of LFSR shifts per frame; legal range 1..255.
- COUNTERSIZE, 4: width of the probability and count fields.
- PROB_DEFAULT, 4'b0011: value of the probability register after reset.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_seed  in  `RNDSIZE  seed value loaded by init_load.
- init_load  in  1  loads init_seed into the LFSR state; highest priority.
- prob_in  in  COUNTERSIZE  new probability code.
- prob_we  in  1  write strobe for prob_in.
- req  in  1  starts a frame; sampled only in IDLE.
- seed_out  out  `RNDSIZE  frame seed delivered to the LFSR stage.
- probability  out  COUNTERSIZE  probability snapshot for the frame.
- count  out  COUNTERSIZE  frame counter.
- seed_valid  out  1  seed_out, probability and count are valid.
- seed_ready  in  1  consumer accepts the bundle.
- busy  out  1  high in STEP or VALID.

## Operation
- LFSR step: fb = s[`RNDSIZE-1] ^ s[3] ^ s[2] ^ s[0]; next state = {s[`RNDSIZE-2:0], fb}. This is the same polynomial the downstream stage uses.
- FSM states:
  - IDLE: on req, go to STEP and load steps_left = STEPS.
  - STEP: shift once per cycle and decrement steps_left. On the last shift, go to VALID, register the post-shift state into seed_out, and register the prob register into probability.
  - VALID: seed_valid=1. When seed_valid & seed_ready, count increments (wraps modulo 2^COUNTERSIZE) and the FSM returns to IDLE.
- The prob register updates on prob_we in any state. The probability output changes only at entry to VALID, so it stays stable while seed_valid is high.
- init_load in any state:
  - loads the LFSR state from init_seed and forces the FSM to IDLE;
  - clears seed_valid next cycle; count and seed_out are unchanged;
  - it overrides req, the handshake and stepping in the same cycle.
- req outside IDLE is ignored, not queued.
- Reset values:
  - LFSR state = 1; seed_out = 0; probability = PROB_DEFAULT;
  - count = 0; seed_valid = 0; busy = 0; FSM = IDLE.

## Timing
- If req is sampled in IDLE at edge N, shifts occur at edges N+1..N+STEPS and seed_valid is high from just after edge N+STEPS. Latency is STEPS+1 cycles.
- Transfer happens at the edge where seed_valid & seed_ready. seed_valid is low the following cycle; seed_ready while seed_valid is low has no effect.
- Minimum frame period with ready held high is STEPS+2 cycles.
- seed_out, probability and count hold unchanged while seed_valid=1 and seed_ready=0, for any duration.
- Reset asserted mid-frame returns all outputs to their reset values immediately, independent of clk.

## Configuration
- LFSR_SEED_LOCKUP_GUARD_EN defined: any load or shift that would leave the LFSR state all-zero writes 1 instead. This covers an init_seed of 0, so the sequence never locks up.
- Not defined: an all-zero state is kept as is. Every subsequent seed_out is then 0 until a nonzero init_load.

## Test plan
- Reset: assert rst asynchronously mid-STEP -> seed_valid=0, busy=0, count=0, seed_out=0, probability=PROB_DEFAULT before the next clk edge.
- Single step: STEPS=1, init_load with init_seed=1, then req -> seed_valid rises 2 cycles after req and seed_out=3.
- Backpressure: hold seed_ready=0 for 10 cycles in VALID -> seed_out, probability and count are constant and seed_valid stays 1. Raise seed_ready -> count goes 0->1 and seed_valid is 0 next cycle.
- Probability snapshot and wrap: prob_we with 4'b0101 during STEP -> probability=5 at VALID. Complete 16 frames -> count returns to 0.
- Abort: init_load mid-STEP with init_seed=1 -> no seed_valid pulse and count unchanged. Next req with STEPS=1 -> seed_out=3.
- Guard: init_load with init_seed=0, STEPS=1, req:
  - with LFSR_SEED_LOCKUP_GUARD_EN -> seed_out=3;
  - without it -> seed_out=0.
